// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Fetch stage: owns the program counter, reads one 32-bit instruction word per
// instruction over a req/ack handshake, holds it in the instruction register
// and exposes the decoded cond/op/funct/rd fields until the datapath signals
// completion with `advance`.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   pc_src            1: next pc is branch_target (word-aligned), 0: pc + 4
//   branch_target     branch / pc-write result from the datapath
//   advance           datapath finished the instruction in the IR
//   imem_req/addr     instruction memory read request and word address
//   imem_ack/rdata    memory returns data this cycle
//   instr, instr_valid instruction register and its live flag (EXEC)
//   cond/op/funct/rd  field slices of instr
//   pc, pc_plus8      address of the IR instruction and the R15 read value
//   align_err         sticky flag: a taken branch target was misaligned
//   retired_count     number of completed instructions (wraps)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        align_err,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        align_err_q, align_err_d;
  logic [31:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      align_err_q <= 1'b0;
      retired_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      align_err_q <= align_err_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    align_err_d = align_err_q;
    retired_d   = retired_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (advance) begin
          // Low target bits are dropped; a misaligned target is only flagged.
          pc_d      = pc_src ? {branch_target[31:2], 2'b00} : pc_q + 32'd4;
          retired_d = retired_q + 32'd1;
          state_d   = StFetch;
          if (pc_src && (branch_target[1:0] != 2'b00)) begin
            align_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state, so req/addr only move on
  // clock edges or async reset.
  assign imem_req      = (state_q == StFetch);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == StExec);
  assign instr         = instr_q;
  assign cond          = instr_q[31:28];
  assign op            = instr_q[27:26];
  assign funct         = instr_q[25:20];
  assign rd            = instr_q[15:12];
  assign pc            = pc_q;
  assign pc_plus8      = pc_q + 32'd8;
  assign align_err     = align_err_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        align_err;
  logic [31:0] retired_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ret = 32'h0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .advance       (advance),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd),
    .pc            (pc),
    .pc_plus8      (pc_plus8),
    .align_err     (align_err),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In FETCH: check request, return word with zero wait, check EXEC view.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    check("fetch_req", {31'h0, imem_req}, 32'h1);
    check("fetch_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("exec_valid", {31'h0, instr_valid}, 32'h1);
    check("exec_req_low", {31'h0, imem_req}, 32'h0);
    check("exec_instr", instr, word);
    check("exec_pc", pc, addr);
  endtask

  // In EXEC: retire the instruction with the given next-pc decision.
  task automatic retire(input logic src, input logic [31:0] target);
    advance       = 1'b1;
    pc_src        = src;
    branch_target = target;
    tick();
    advance       = 1'b0;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    exp_ret       = exp_ret + 32'd1;
    check("retired", retired_count, exp_ret);
  endtask

  initial begin
    rst           = 1'b0;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    advance       = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    #12;

    // Reset state
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_fields", {20'h0, cond, op, funct}, 32'h0);
    check("rst_pc_plus8", pc_plus8, 32'h8);
    check("rst_align", {31'h0, align_err}, 32'h0);
    check("rst_retired", retired_count, 32'h0);

    // Release: IDLE -> FETCH on first edge, zero-wait fetch of E3A01005
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    fetch(32'h0, 32'hE3A0_1005);
    check("dec_cond", {28'h0, cond}, 32'hE);
    check("dec_op", {30'h0, op}, 32'h0);
    check("dec_funct", {26'h0, funct}, 32'h3A);
    check("dec_rd", {28'h0, rd}, 32'h1);
    check("dec_pc_plus8", pc_plus8, 32'h8);

    // advance held low holds EXEC and the IR
    tick(); tick();
    check("hold_valid", {31'h0, instr_valid}, 32'h1);
    check("hold_instr", instr, 32'hE3A0_1005);
    check("hold_retired", retired_count, 32'h0);
    retire(1'b0, 32'h0);

    // 3 wait states at address 4; stray advance ignored in FETCH
    for (int i = 0; i < 3; i++) begin
      advance = 1'b1;
      check("wait_req", {31'h0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h4);
      check("wait_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
    advance = 1'b0;
    check("wait_retired", retired_count, 32'h1);
    fetch(32'h4, 32'hE281_1001);

    // Sequential run
    retire(1'b0, 32'h0);
    fetch(32'h8, 32'hE080_2001);
    retire(1'b0, 32'h0);
    fetch(32'hC, 32'hE151_0002);
    check("seq_retired", retired_count, 32'h3);
    retire(1'b0, 32'h0);
    check("seq_retired4", retired_count, 32'h4);
    fetch(32'h10, 32'hEA00_003B);

    // Misaligned taken branch
    retire(1'b1, 32'h0000_0102);
    check("br_addr", imem_addr, 32'h0000_0100);
    check("br_align", {31'h0, align_err}, 32'h1);
    fetch(32'h100, 32'hEAFF_FFFE);

    // Aligned branch to top of memory: align_err stays set
    retire(1'b1, 32'hFFFF_FFFC);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_align", {31'h0, align_err}, 32'h1);
    fetch(32'hFFFF_FFFC, 32'hE1A0_0000);
    check("top_pc_plus8", pc_plus8, 32'h0000_0004);

    // PC wraps
    retire(1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc_plus8", pc_plus8, 32'h8);

    // Reset mid-FETCH with ack on the reset edge
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    rst        = 1'b0;
    #1;
    check("arst_req_drop", {31'h0, imem_req}, 32'h0);
    tick();
    imem_ack = 1'b0;
    check("arst_instr", instr, 32'h0);
    check("arst_pc", pc, 32'h0);
    check("arst_retired", retired_count, 32'h0);
    check("arst_align", {31'h0, align_err}, 32'h0);
    check("arst_valid", {31'h0, instr_valid}, 32'h0);
    rst     = 1'b1;
    exp_ret = 32'h0;
    tick();
    fetch(32'h0, 32'hE3A0_2007);
    check("restart_rd", {28'h0, rd}, 32'h2);
    retire(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage of the ARM-subset processor: owns the program counter, fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, and holds each word in an instruction register. It splits the word into the cond/op/funct/rd fields consumed by the control unit, then waits for the datapath to finish the instruction. The next PC is taken from the control unit's `pc_src` decision.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_src`  in  1  control unit: 1 = next PC is `branch_target`, 0 = PC+4.
- `branch_target`  in  32  branch/PC-write result from the datapath.
- `advance`  in  1  datapath has completed the instruction in the IR.
- `imem_req`  out  1  instruction memory read request.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  memory has data on `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register.
- `instr_valid`  out  1  IR holds a live instruction (EXEC state).
- `cond`  out  4  `instr[31:28]`.
- `op`  out  2  `instr[27:26]`.
- `funct`  out  6  `instr[25:20]`.
- `rd`  out  4  `instr[15:12]`.
- `pc`  out  32  address of the instruction in the IR.
- `pc_plus8`  out  32  `pc + 8`, the ARM R15 read value.
- `align_err`  out  1  sticky; a taken branch target had nonzero `[1:0]`.
- `retired_count`  out  32  number of instructions completed.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: entered only on reset. Moves to FETCH on the first clock edge with `rst` high.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack.
  - On an edge with `imem_ack`=1: `instr` <= `imem_rdata`, go to EXEC.
  - Otherwise stay in FETCH with no timeout.
- EXEC:
  - `instr_valid`=1 and `imem_req`=0.
  - On an edge with `advance`=1:
    - `pc` <= `pc_src` ? {`branch_target[31:2]`,2'b00} : `pc`+4.
    - `retired_count` += 1.
    - Go to FETCH.
  - If `pc_src`=1 and `branch_target[1:0]`≠0 on that edge, set `align_err`. It stays set until reset.
- `pc_src`, `branch_target` and `advance` are ignored outside EXEC.
- `imem_ack` and `imem_rdata` are ignored outside FETCH.
- Field outputs are pure slices of `instr`. `pc_plus8` is combinational from `pc`.
- Arithmetic is modulo 2^32:
  - `pc` 32'hFFFF_FFFC + 4 wraps to 0.
  - `pc_plus8` wraps the same way.
  - `retired_count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, `pc`=`RESET_PC`, `instr`=0.
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `align_err`=0, `retired_count`=0.
  - Field outputs are therefore 0 and `pc_plus8`=`RESET_PC`+8.
- Reset during FETCH: `imem_req` drops in the same cycle, without waiting for a clock edge.
  - An ack arriving on the edge of or after reset assertion is discarded.
- Reset during EXEC: the instruction is abandoned and not counted.
- `imem_req` and `imem_addr` are decoded from state and `pc`. They change only on clock edges or on async reset.
- Ack on the first FETCH cycle gives `instr_valid` on the next cycle. The minimum instruction period is 2 cycles (1 FETCH + 1 EXEC).
- Memory wait states add 1 cycle each to FETCH.
- `advance` held high continuously gives one retirement per EXEC cycle. `advance` held low holds EXEC and the IR indefinitely.
- Ack and advance cannot coincide, because they belong to different states.
- The updated `pc` appears the cycle after the `advance` edge and equals the new `imem_addr` in that same cycle.

## Test plan
- Reset release, `RESET_PC`=0, memory returns 32'hE3A0_1005 with zero wait → `imem_req`=1 with `imem_addr`=0 in the first FETCH cycle. The next cycle shows `instr_valid`=1, `cond`=4'hE, `op`=2'b00, `funct`=6'b111010, `rd`=4'h1, `pc_plus8`=8.
- 3 wait cycles before ack → `imem_addr` stable at 0 for 4 cycles; `instr_valid` rises on cycle 5; `retired_count` stays 0 until `advance`.
- Sequential run of 4 instructions, `pc_src`=0, `advance`=1 → fetch addresses 0,4,8,12 and `retired_count`=4.
- Taken branch, `pc_src`=1, `branch_target`=32'h0000_0102 → next `imem_addr`=32'h0000_0100 and `align_err`=1, which stays 1 after later aligned branches.
- `pc`=32'hFFFF_FFFC, advance with `pc_src`=0 → next `imem_addr`=0 and `pc_plus8` of the old instruction = 32'h0000_0004.
- `rst` asserted mid-FETCH with ack in the same cycle, then released → `imem_req` drops immediately; `instr`=0, `pc`=`RESET_PC`, `retired_count`=0; the fetch restarts at `RESET_PC`.
